// File: rtl/onewire_pkg.sv
// Shared definitions for the 1-Wire master: FSM state encoding and the
// standard-speed bus timing defaults in microseconds.
package onewire_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RST_LOW   = 3'd1,
        ST_RST_WAIT  = 3'd2,
        ST_RST_REC   = 3'd3,
        ST_SLOT_LOW  = 3'd4,
        ST_SLOT_WAIT = 3'd5,
        ST_SLOT_END  = 3'd6
    } ow_state_e;

    localparam int DEF_CLK_FREQ_MHZ     = 10;
    localparam int DEF_T_RST_LOW_US     = 480;
    localparam int DEF_T_PRES_SAMPLE_US = 70;
    localparam int DEF_T_RST_REC_US     = 480;
    localparam int DEF_T_SLOT_US        = 70;
    localparam int DEF_T_LOW1_US        = 6;
    localparam int DEF_T_LOW0_US        = 60;
    localparam int DEF_T_SAMPLE_US      = 15;
    localparam int DEF_T_REC_US         = 10;

endpackage

// File: rtl/onewire_master_sync.sv
// Two-flop synchronizer for the asynchronous open-drain bus level.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of its neighbour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/onewire_master.sv
// 1-Wire bus master timing engine: reset/presence sequence and 8-bit
// LSB-first write/read slots on an open-drain bus.
module onewire_master
    import onewire_pkg::*;
#(
    parameter int CLK_FREQ_MHZ     = DEF_CLK_FREQ_MHZ,
    parameter int T_RST_LOW_US     = DEF_T_RST_LOW_US,
    parameter int T_PRES_SAMPLE_US = DEF_T_PRES_SAMPLE_US,
    parameter int T_RST_REC_US     = DEF_T_RST_REC_US,
    parameter int T_SLOT_US        = DEF_T_SLOT_US,
    parameter int T_LOW1_US        = DEF_T_LOW1_US,
    parameter int T_LOW0_US        = DEF_T_LOW0_US,
    parameter int T_SAMPLE_US      = DEF_T_SAMPLE_US,
    parameter int T_REC_US         = DEF_T_REC_US
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic start_reset,
    input  logic start_write,
    input  logic start_read,
    input  logic data_to_send,
    output logic shift,
    output logic data_received,
    output logic ready,
    output logic done,
    output logic present_status,
    output logic ow_drive_low,
    input  logic ow_in
);

    localparam int CNT_W        = $clog2(T_RST_LOW_US * CLK_FREQ_MHZ + 1);
    localparam int RST_LOW_CYC  = T_RST_LOW_US * CLK_FREQ_MHZ;
    localparam int PRES_CYC     = T_PRES_SAMPLE_US * CLK_FREQ_MHZ;
    localparam int RST_REC_CYC  = T_RST_REC_US * CLK_FREQ_MHZ;
    localparam int LOW1_CYC     = T_LOW1_US * CLK_FREQ_MHZ;
    localparam int LOW0_CYC     = T_LOW0_US * CLK_FREQ_MHZ;
    localparam int SAMPLE_CYC   = T_SAMPLE_US * CLK_FREQ_MHZ;
    localparam int SLOT_END_CYC = (T_SLOT_US + T_REC_US) * CLK_FREQ_MHZ;

    ow_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic             tx_bit_q, tx_bit_d;
    logic             writing_q, writing_d;
    logic             rx_bit_q, rx_bit_d;
    logic             present_q, present_d;
    logic             drive_q, drive_d;
    logic             shift_q, shift_d;
    logic             done_q, done_d;
    logic             ready_q, ready_d;
    logic             bus_sync;
    logic             in_slot;
    logic [CNT_W-1:0] low_last;

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (ow_in),
        .q     (bus_sync)
    );

    assign in_slot  = (state_q == ST_SLOT_LOW) || (state_q == ST_SLOT_WAIT) ||
                      (state_q == ST_SLOT_END);
    assign low_last = tx_bit_q ? CNT_W'(LOW1_CYC - 1) : CNT_W'(LOW0_CYC - 1);

    always_comb begin
        // NOTE: every variable gets its default first so no path infers a latch.
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        bit_cnt_d = bit_cnt_q;
        tx_bit_d  = tx_bit_q;
        writing_d = writing_q;
        rx_bit_d  = rx_bit_q;
        present_d = present_q;
        shift_d   = 1'b0;
        done_d    = 1'b0;

        if (!enable) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    if (start_reset) begin
                        state_d   = ST_RST_LOW;
                        present_d = 1'b0;
                    end else if (start_write) begin
                        state_d   = ST_SLOT_LOW;
                        writing_d = 1'b1;
                        tx_bit_d  = data_to_send;
                    end else if (start_read) begin
                        state_d   = ST_SLOT_LOW;
                        writing_d = 1'b0;
                        tx_bit_d  = 1'b1;
                    end
                end
                ST_RST_LOW: begin
                    if (cnt_q == CNT_W'(RST_LOW_CYC - 1)) begin
                        state_d = ST_RST_WAIT;
                        cnt_d   = '0;
                    end
                end
                ST_RST_WAIT: begin
                    if (cnt_q == CNT_W'(PRES_CYC - 1)) begin
                        state_d   = ST_RST_REC;
                        present_d = ~bus_sync;
                    end
                end
                ST_RST_REC: begin
                    if (cnt_q == CNT_W'(RST_REC_CYC - 1)) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end
                end
                ST_SLOT_LOW: begin
                    if (cnt_q == low_last) state_d = ST_SLOT_WAIT;
                end
                ST_SLOT_WAIT: begin
                    if (cnt_q >= CNT_W'(SAMPLE_CYC - 1)) state_d = ST_SLOT_END;
                end
                ST_SLOT_END: begin
                    // Strobe early so the upstream shift lands before the next slot captures data_to_send.
                    if (cnt_q == CNT_W'(SLOT_END_CYC - 3)) shift_d = 1'b1;
                    if (cnt_q == CNT_W'(SLOT_END_CYC - 1)) begin
                        cnt_d     = '0;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        tx_bit_d  = writing_q ? data_to_send : 1'b1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_SLOT_LOW;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase

            if (in_slot && cnt_q == CNT_W'(SAMPLE_CYC - 1)) rx_bit_d = bus_sync;
        end

        drive_d = enable && ((state_d == ST_RST_LOW) || (state_d == ST_SLOT_LOW));
        ready_d = enable && (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            tx_bit_q  <= 1'b0;
            writing_q <= 1'b0;
            rx_bit_q  <= 1'b0;
            present_q <= 1'b0;
            drive_q   <= 1'b0;
            shift_q   <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            tx_bit_q  <= tx_bit_d;
            writing_q <= writing_d;
            rx_bit_q  <= rx_bit_d;
            present_q <= present_d;
            drive_q   <= drive_d;
            shift_q   <= shift_d;
            done_q    <= done_d;
            ready_q   <= ready_d;
        end
    end

    assign shift          = shift_q;
    assign data_received  = rx_bit_q;
    assign ready          = ready_q;
    assign done           = done_q;
    assign present_status = present_q;
    assign ow_drive_low   = drive_q;

endmodule

// File: tb/tb_onewire_master.sv
// Directed bench for onewire_master with a bus/device model, a TX shift
// register model and queue-based expected results.
module tb_onewire_master;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    logic start_reset = 1'b0;
    logic start_write = 1'b0;
    logic start_read = 1'b0;
    logic data_to_send;
    logic shift, data_received, ready, done, present_status, ow_drive_low;
    logic ow_in;

    logic       dev_pres_low = 1'b0;
    logic       dev_read_low = 1'b0;
    int         dev_mode = 0;
    logic [7:0] read_mask = 8'h00;
    logic [7:0] tx_reg = 8'h00;
    logic [7:0] tx_val = 8'h00;
    logic       tx_load = 1'b0;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int epoch = 0;
    int seen_epoch = 0;

    int   obs_low[$];
    logic obs_rx[$];
    int   shift_cyc[$];
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   first_low_cyc = -1;
    int   low_run = 0;

    int   exp_low[$];
    logic exp_rx[$];

    onewire_master dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .start_reset    (start_reset),
        .start_write    (start_write),
        .start_read     (start_read),
        .data_to_send   (data_to_send),
        .shift          (shift),
        .data_received  (data_received),
        .ready          (ready),
        .done           (done),
        .present_status (present_status),
        .ow_drive_low   (ow_drive_low),
        .ow_in          (ow_in)
    );

    always #5 clk = ~clk;

    assign data_to_send = tx_reg[0];
    assign ow_in = ~(ow_drive_low | dev_pres_low | dev_read_low);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tx_load) tx_reg <= tx_val;
        else if (shift) tx_reg <= tx_reg >> 1;
    end

    // Presence responder: pulls the bus low 30..180 us after master release.
    always begin
        @(negedge ow_drive_low);
        if (dev_mode == 1) begin
            repeat (300) @(posedge clk);
            dev_pres_low = 1'b1;
            repeat (1500) @(posedge clk);
            dev_pres_low = 1'b0;
        end
    end

    // Read responder: holds the bus low for 30 us on slots flagged in read_mask.
    always begin
        int slot;
        @(posedge ow_drive_low);
        slot = obs_rx.size();
        if (dev_mode == 2 && slot < 8 && read_mask[slot[2:0]]) begin
            dev_read_low = 1'b1;
            repeat (300) @(posedge clk);
            dev_read_low = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (epoch != seen_epoch) begin
            seen_epoch = epoch;
            obs_low.delete();
            obs_rx.delete();
            shift_cyc.delete();
            done_cnt = 0;
            done_cyc = 0;
            first_low_cyc = -1;
            low_run = 0;
        end
        if (ow_drive_low === 1'b1) begin
            if (low_run == 0 && first_low_cyc < 0) first_low_cyc = cyc;
            low_run++;
        end else if (low_run != 0) begin
            obs_low.push_back(low_run);
            low_run = 0;
        end
        if (shift === 1'b1) begin
            obs_rx.push_back(data_received);
            shift_cyc.push_back(cyc);
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic r, input logic w, input logic rd);
        start_reset = r;
        start_write = w;
        start_read  = rd;
        @(negedge clk);
        start_reset = 1'b0;
        start_write = 1'b0;
        start_read  = 1'b0;
    endtask

    task automatic load_tx(input logic [7:0] v);
        tx_val  = v;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
    endtask

    task automatic wait_done(input int max, input string tag);
        int n = 0;
        while (done !== 1'b1 && n < max) begin
            @(negedge clk);
            n++;
        end
        check(tag, done, 1'b1);
    endtask

    task automatic wait_drive(input logic level, input int max, input string tag);
        int n = 0;
        while (ow_drive_low !== level && n < max) begin
            @(negedge clk);
            n++;
        end
        check(tag, ow_drive_low, level);
    endtask

    task automatic wait_shifts(input int count, input int max, input string tag);
        int n = 0;
        while (obs_rx.size() < count && n < max) begin
            @(negedge clk);
            n++;
        end
        check(tag, obs_rx.size(), count);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_shift"}, shift, 1'b0);
        check({tag, "_rx"}, data_received, 1'b0);
        check({tag, "_ready"}, ready, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_present"}, present_status, 1'b0);
        check({tag, "_drive"}, ow_drive_low, 1'b0);
    endtask

    initial begin
        logic [7:0] exp_byte;

        // Reset state
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        enable = 1'b1;
        repeat (2) @(negedge clk);
        check("enable_ready", ready, 1'b1);

        // Reset sequence with a device answering
        epoch++;
        dev_mode = 1;
        @(negedge clk);
        pulse(1'b1, 1'b0, 1'b0);
        wait_done(11000, "rst_dev_done_seen");
        check("rst_dev_ready", ready, 1'b1);
        repeat (5) @(negedge clk);
        check("rst_dev_low_count", obs_low.size(), 1);
        check("rst_dev_low_width", obs_low[0], 4800);
        check("rst_dev_done_count", done_cnt, 1);
        check("rst_dev_done_time", done_cyc - first_low_cyc, 9600);
        check("rst_dev_present", present_status, 1'b1);

        // Reset sequence with an empty bus
        epoch++;
        dev_mode = 0;
        @(negedge clk);
        pulse(1'b1, 1'b0, 1'b0);
        wait_done(11000, "rst_nodev_done_seen");
        repeat (5) @(negedge clk);
        check("rst_nodev_present", present_status, 1'b0);
        check("rst_nodev_done_count", done_cnt, 1);
        check("rst_nodev_done_time", done_cyc - first_low_cyc, 9600);

        // Write 0xA5, with a read request arriving while busy
        epoch++;
        load_tx(8'hA5);
        for (int i = 0; i < 8; i++) begin
            exp_low.push_back(tx_val[i] ? 60 : 600);
            exp_rx.push_back(tx_val[i]);
        end
        pulse(1'b0, 1'b1, 1'b0);
        repeat (2000) @(negedge clk);
        pulse(1'b0, 1'b0, 1'b1);
        wait_done(8000, "wr_done_seen");
        repeat (5) @(negedge clk);
        check("wr_low_count", obs_low.size(), 8);
        for (int i = 0; i < 8; i++) check($sformatf("wr_low_width_%0d", i), obs_low[i], exp_low.pop_front());
        check("wr_shift_count", obs_rx.size(), 8);
        for (int i = 0; i < 8; i++) check($sformatf("wr_rx_%0d", i), obs_rx[i], exp_rx.pop_front());
        for (int i = 1; i < 8; i++) check($sformatf("wr_shift_gap_%0d", i), shift_cyc[i] - shift_cyc[i-1], 800);
        check("wr_done_count", done_cnt, 1);
        check("wr_done_after_last_shift", done_cyc - shift_cyc[7], 2);

        // Read with the device pulling bits 1, 3 and 6 low
        epoch++;
        dev_mode = 2;
        read_mask = 8'b0100_1010;
        exp_byte = 8'hB5;
        for (int i = 0; i < 8; i++) begin
            exp_low.push_back(60);
            exp_rx.push_back(exp_byte[i]);
        end
        @(negedge clk);
        pulse(1'b0, 1'b0, 1'b1);
        wait_done(8000, "rd_done_seen");
        repeat (5) @(negedge clk);
        check("rd_low_count", obs_low.size(), 8);
        for (int i = 0; i < 8; i++) check($sformatf("rd_low_width_%0d", i), obs_low[i], exp_low.pop_front());
        check("rd_shift_count", obs_rx.size(), 8);
        for (int i = 0; i < 8; i++) check($sformatf("rd_rx_%0d", i), obs_rx[i], exp_rx.pop_front());
        check("rd_done_count", done_cnt, 1);
        dev_mode = 0;

        // Simultaneous reset and write: reset wins
        epoch++;
        dev_mode = 1;
        @(negedge clk);
        pulse(1'b1, 1'b1, 1'b0);
        wait_done(11000, "prio_done_seen");
        repeat (5) @(negedge clk);
        check("prio_low_count", obs_low.size(), 1);
        check("prio_low_width", obs_low[0], 4800);
        check("prio_shift_count", obs_rx.size(), 0);
        check("prio_present", present_status, 1'b1);
        check("prio_done_count", done_cnt, 1);
        dev_mode = 0;

        // Enable drop during bit 3 of a write
        epoch++;
        load_tx(8'hFF);
        pulse(1'b0, 1'b1, 1'b0);
        wait_shifts(3, 4000, "abort_three_shifts");
        wait_drive(1'b1, 100, "abort_slot3_start");
        repeat (10) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("abort_drive_next", ow_drive_low, 1'b0);
        check("abort_ready_next", ready, 1'b0);
        repeat (1000) @(negedge clk);
        check("abort_shift_count", obs_rx.size(), 3);
        check("abort_done_count", done_cnt, 0);
        check("abort_ready_held", ready, 1'b0);
        check("abort_drive_held", ow_drive_low, 1'b0);
        enable = 1'b1;
        repeat (2) @(negedge clk);
        check("abort_ready_back", ready, 1'b1);

        // Asynchronous reset in the middle of a slot
        epoch++;
        load_tx(8'h00);
        pulse(1'b0, 1'b1, 1'b0);
        wait_drive(1'b1, 100, "areset_slot_start");
        repeat (20) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("areset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("areset_ready_back", ready, 1'b1);
        check("areset_drive_idle", ow_drive_low, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
